seq_ctrl: RTL and testbench

- Microprogram sequencer control core of the AM2910-style next-address unit.
- Decodes the 4-bit microinstruction and the condition code, and selects next address Y from D, R, the stack top F, or uPC.
- Owns the microprogram counter (uPC) and the register/counter (R).
- Drives the push/pop/clear side of the external LIFO stack and consumes its top-of-stack, full and empty outputs. It is the initiator for the stack block.

---
 rtl/seq_pkg.sv | 40 ++++
 rtl/seq_decode.sv | 106 ++++++++++
 rtl/seq_ctrl.sv | 112 +++++++++++
 tb/tb_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the AM2910-style microprogram sequencer:
//   - ADDR_W_DEFAULT : default microprogram address width
//   - OP_*           : 4-bit microinstruction opcodes
//   - SEL_*          : next-address (Y) source select encoding
//   - RA_*           : register/counter (R) update action encoding
// ---------------------------------------------------------------------------
package seq_pkg;

   localparam int ADDR_W_DEFAULT = 12;

   localparam logic [3:0] OP_JZ   = 4'd0;
   localparam logic [3:0] OP_CJS  = 4'd1;
   localparam logic [3:0] OP_JMAP = 4'd2;
   localparam logic [3:0] OP_CJP  = 4'd3;
   localparam logic [3:0] OP_PUSH = 4'd4;
   localparam logic [3:0] OP_JSRP = 4'd5;
   localparam logic [3:0] OP_CJV  = 4'd6;
   localparam logic [3:0] OP_JRP  = 4'd7;
   localparam logic [3:0] OP_RFCT = 4'd8;
   localparam logic [3:0] OP_RPCT = 4'd9;
   localparam logic [3:0] OP_CRTN = 4'd10;
   localparam logic [3:0] OP_CJPP = 4'd11;
   localparam logic [3:0] OP_LDCT = 4'd12;
   localparam logic [3:0] OP_LOOP = 4'd13;
   localparam logic [3:0] OP_CONT = 4'd14;
   localparam logic [3:0] OP_TWB  = 4'd15;

   localparam logic [2:0] SEL_D    = 3'd0;
   localparam logic [2:0] SEL_R    = 3'd1;
   localparam logic [2:0] SEL_F    = 3'd2;
   localparam logic [2:0] SEL_UPC  = 3'd3;
   localparam logic [2:0] SEL_ZERO = 3'd4;

   localparam logic [1:0] RA_NONE = 2'd0;
   localparam logic [1:0] RA_DEC  = 2'd1;
   localparam logic [1:0] RA_LOAD = 2'd2;

endpackage

// File: rtl/seq_decode.sv
// ---------------------------------------------------------------------------
// seq_decode
// Purely combinational microinstruction decoder.
// Ports:
//   instr  in  4  opcode
//   pass   in  1  condition test result (1 = pass)
//   rz     in  1  R register is zero
//   sel    out 3  Y source select (SEL_*)
//   push   out 1  stack push request
//   pop    out 1  stack pop request
//   clear  out 1  stack clear request
//   r_act  out 2  R update action (RA_*)
//   pl_n   out 1  pipeline-register enable, active low
//   map_n  out 1  mapping-PROM enable, active low
//   vect_n out 1  vector-PROM enable, active low
// ---------------------------------------------------------------------------
module seq_decode
   import seq_pkg::*;
(
   input  logic [3:0] instr,
   input  logic       pass,
   input  logic       rz,
   output logic [2:0] sel,
   output logic       push,
   output logic       pop,
   output logic       clear,
   output logic [1:0] r_act,
   output logic       pl_n,
   output logic       map_n,
   output logic       vect_n
);

   always_comb begin
      sel   = SEL_UPC;
      push  = 1'b0;
      pop   = 1'b0;
      clear = 1'b0;
      r_act = RA_NONE;
      case (instr)
         OP_JZ: begin
            sel   = SEL_ZERO;
            clear = 1'b1;
         end
         OP_CJS: begin
            sel  = pass ? SEL_D : SEL_UPC;
            push = pass;
         end
         OP_JMAP: sel = SEL_D;
         OP_CJP:  sel = pass ? SEL_D : SEL_UPC;
         OP_PUSH: begin
            push  = 1'b1;
            r_act = pass ? RA_LOAD : RA_NONE;
         end
         OP_JSRP: begin
            sel  = pass ? SEL_D : SEL_R;
            push = 1'b1;
         end
         OP_CJV: sel = pass ? SEL_D : SEL_UPC;
         OP_JRP: sel = pass ? SEL_D : SEL_R;
         OP_RFCT: begin
            // Loop back to the stacked address until the count runs out.
            sel   = rz ? SEL_UPC : SEL_F;
            pop   = rz;
            r_act = rz ? RA_NONE : RA_DEC;
         end
         OP_RPCT: begin
            sel   = rz ? SEL_UPC : SEL_D;
            r_act = rz ? RA_NONE : RA_DEC;
         end
         OP_CRTN: begin
            sel = pass ? SEL_F : SEL_UPC;
            pop = pass;
         end
         OP_CJPP: begin
            sel = pass ? SEL_D : SEL_UPC;
            pop = pass;
         end
         OP_LDCT: r_act = RA_LOAD;
         OP_LOOP: begin
            sel = pass ? SEL_UPC : SEL_F;
            pop = pass;
         end
         OP_CONT: sel = SEL_UPC;
         OP_TWB: begin
            // Three-way branch: exit on pass, count via F, or branch to D
            // once the counter is exhausted.
            if (pass) begin
               sel = SEL_UPC;
               pop = 1'b1;
            end else if (!rz) begin
               sel   = SEL_F;
               r_act = RA_DEC;
            end else begin
               sel = SEL_D;
               pop = 1'b1;
            end
         end
         default: sel = SEL_UPC;
      endcase
   end

   assign map_n  = (instr != OP_JMAP);
   assign vect_n = (instr != OP_CJV);
   assign pl_n   = (instr == OP_JMAP) || (instr == OP_CJV);

endmodule

// File: rtl/seq_ctrl.sv
// ---------------------------------------------------------------------------
// seq_ctrl
// Microprogram sequencer control core: owns uPC and R, selects Y and drives
// the request side of an external LIFO stack.
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   instr[3:0]            microinstruction opcode
//   cc_n, ccen_n          condition code / condition enable (active low)
//   ci                    carry into the uPC incrementer
//   rld_n                 unconditional R load from D (active low)
//   d_in                  direct address / count input
//   y_out                 next microprogram address (combinational)
//   pl_n, map_n, vect_n   source enables (exactly one low)
//   full_n                stack-full flag (inverted stk_full)
//   stk_push/pop/clear    stack requests, stk_din = push data (uPC)
//   stk_dout              stack top F
//   stk_full, stk_empty   stack status
// ---------------------------------------------------------------------------
module seq_ctrl
   import seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [3:0]        instr,
   input  logic              cc_n,
   input  logic              ccen_n,
   input  logic              ci,
   input  logic              rld_n,
   input  logic [ADDR_W-1:0] d_in,
   output logic [ADDR_W-1:0] y_out,
   output logic              pl_n,
   output logic              map_n,
   output logic              vect_n,
   output logic              full_n,
   output logic              stk_push,
   output logic              stk_pop,
   output logic              stk_clear,
   output logic [ADDR_W-1:0] stk_din,
   input  logic [ADDR_W-1:0] stk_dout,
   input  logic              stk_full,
   input  logic              stk_empty
);

   logic [ADDR_W-1:0] upc;
   logic [ADDR_W-1:0] r_reg;
   logic              pass;
   logic              rz;
   logic [2:0]        sel;
   logic              push;
   logic              pop;
   logic              clear;
   logic [1:0]        r_act;
   logic              empty_unused;

   assign pass = ccen_n | ~cc_n;
   assign rz   = (r_reg == '0);

   // Empty is status only; the stack returns F=0 when empty.
   assign empty_unused = stk_empty;

   seq_decode u_decode (
      .instr  (instr),
      .pass   (pass),
      .rz     (rz),
      .sel    (sel),
      .push   (push),
      .pop    (pop),
      .clear  (clear),
      .r_act  (r_act),
      .pl_n   (pl_n),
      .map_n  (map_n),
      .vect_n (vect_n)
   );

   always_comb begin
      y_out = upc;
      case (sel)
         SEL_D:    y_out = d_in;
         SEL_R:    y_out = r_reg;
         SEL_F:    y_out = stk_dout;
         SEL_ZERO: y_out = '0;
         default:  y_out = upc;
      endcase
   end

   // Gate requests with reset so no stack operation leaks out while held.
   assign stk_push  = push  & reset_n;
   assign stk_pop   = pop   & reset_n;
   assign stk_clear = clear & reset_n;
   assign stk_din   = upc;
   assign full_n    = ~stk_full;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         upc   <= '0;
         r_reg <= '0;
      end else begin
         upc <= y_out + {{(ADDR_W-1){1'b0}}, ci};
         // External load wins over both decrement and opcode load.
         if (!rld_n)
            r_reg <= d_in;
         else if (r_act == RA_LOAD)
            r_reg <= d_in;
         else if (r_act == RA_DEC)
            r_reg <= r_reg - {{(ADDR_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_seq_ctrl.sv
module tb_seq_ctrl;
   import seq_pkg::*;

   localparam int AW = 12;

   logic          clk;
   logic          reset_n;
   logic [3:0]    instr;
   logic          cc_n;
   logic          ccen_n;
   logic          ci;
   logic          rld_n;
   logic [AW-1:0] d_in;
   logic [AW-1:0] y_out;
   logic          pl_n;
   logic          map_n;
   logic          vect_n;
   logic          full_n;
   logic          stk_push;
   logic          stk_pop;
   logic          stk_clear;
   logic [AW-1:0] stk_din;
   logic [AW-1:0] stk_dout;
   logic          stk_full;
   logic          stk_empty;

   int errors = 0;
   int checks = 0;

   seq_ctrl #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .instr     (instr),
      .cc_n      (cc_n),
      .ccen_n    (ccen_n),
      .ci        (ci),
      .rld_n     (rld_n),
      .d_in      (d_in),
      .y_out     (y_out),
      .pl_n      (pl_n),
      .map_n     (map_n),
      .vect_n    (vect_n),
      .full_n    (full_n),
      .stk_push  (stk_push),
      .stk_pop   (stk_pop),
      .stk_clear (stk_clear),
      .stk_din   (stk_din),
      .stk_dout  (stk_dout),
      .stk_full  (stk_full),
      .stk_empty (stk_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Condition fails: ccen_n=0 with cc_n=1
   task automatic cond(input logic p);
      ccen_n = 1'b0;
      cc_n   = ~p;
   endtask

   initial begin
      reset_n   = 1'b0;
      instr     = OP_JZ;
      cc_n      = 1'b1;
      ccen_n    = 1'b1;
      ci        = 1'b0;
      rld_n     = 1'b1;
      d_in      = '0;
      stk_dout  = '0;
      stk_full  = 1'b0;
      stk_empty = 1'b1;
      #2;
      // Reset: requests forced low even when decode asks for a clear
      chk("rst_clear", stk_clear, 0);
      instr = OP_CONT;
      #1;
      chk("rst_y", y_out, 0);
      chk("rst_push_pop", {stk_push, stk_pop}, 0);
      chk("rst_pl_n", pl_n, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // CONT x3 with ci=1
      ci = 1'b1;
      #1;
      chk("cont0_y", y_out, 12'h000);
      tick();
      chk("cont1_y", y_out, 12'h001);
      tick();
      chk("cont2_y", y_out, 12'h002);
      chk("cont2_req", {stk_push, stk_pop, stk_clear}, 0);
      tick();
      ci = 1'b0;
      #1;
      chk("cont_upc3", y_out, 12'h003);

      // Move uPC to 0x010, then CJS fail and pass
      instr = OP_CJP; cond(1'b1); d_in = 12'h010;
      #1;
      chk("cjp_pass_y", y_out, 12'h010);
      tick();
      instr = OP_CJS; cond(1'b0); d_in = 12'h123;
      #1;
      chk("cjs_fail_y", y_out, 12'h010);
      chk("cjs_fail_push", stk_push, 0);
      cond(1'b1);
      #1;
      chk("cjs_y", y_out, 12'h123);
      chk("cjs_push", stk_push, 1);
      chk("cjs_din", stk_din, 12'h010);
      chk("cjs_pop", stk_pop, 0);
      tick();
      instr = OP_CRTN; stk_dout = 12'h010; stk_empty = 1'b0;
      #1;
      chk("crtn_y", y_out, 12'h010);
      chk("crtn_pop", stk_pop, 1);
      chk("crtn_push", stk_push, 0);
      tick();

      // LDCT 3 then RPCT x4
      instr = OP_LDCT; d_in = 12'h003;
      #1;
      chk("ldct_y", y_out, 12'h010);
      tick();
      instr = OP_JRP; cond(1'b0);
      #1;
      chk("r_after_ldct", y_out, 12'h003);
      instr = OP_RPCT; d_in = 12'h050; ci = 1'b1;
      #1;
      chk("rpct1_y", y_out, 12'h050);
      tick();
      chk("rpct2_y", y_out, 12'h050);
      tick();
      chk("rpct3_y", y_out, 12'h050);
      tick();
      chk("rpct4_y", y_out, 12'h051);
      ci = 1'b0;
      tick();
      instr = OP_JRP;
      #1;
      chk("rpct_r_zero", y_out, 12'h000);

      // PUSH D=2 then RFCT x3
      instr = OP_PUSH; ccen_n = 1'b1; d_in = 12'h002;
      #1;
      chk("push_y", y_out, 12'h051);
      chk("push_req", stk_push, 1);
      chk("push_din", stk_din, 12'h051);
      tick();
      instr = OP_RFCT; stk_dout = 12'h200;
      #1;
      chk("rfct1_y", y_out, 12'h200);
      chk("rfct1_pop", stk_pop, 0);
      tick();
      chk("rfct2_y", y_out, 12'h200);
      tick();
      chk("rfct3_y", y_out, 12'h200);
      chk("rfct3_pop", stk_pop, 1);
      tick();

      // JZ from 0x7FF
      instr = OP_CJP; ccen_n = 1'b1; d_in = 12'h7FF;
      tick();
      instr = OP_JZ;
      #1;
      chk("jz_y", y_out, 12'h000);
      chk("jz_clear", stk_clear, 1);
      chk("jz_push_pop", {stk_push, stk_pop}, 0);
      tick();
      instr = OP_CONT;
      #1;
      chk("jz_upc", y_out, 12'h000);

      // rld_n overrides RFCT decrement
      instr = OP_LDCT; d_in = 12'h005;
      tick();
      instr = OP_RFCT; rld_n = 1'b0; d_in = 12'h009; stk_dout = 12'h300;
      #1;
      chk("rld_rfct_y", y_out, 12'h300);
      tick();
      rld_n = 1'b1;
      instr = OP_JRP; cond(1'b0);
      #1;
      chk("rld_r", y_out, 12'h009);

      // TWB with rz=0
      instr = OP_TWB; cond(1'b0); stk_dout = 12'h3A5;
      #1;
      chk("twb_fail_y", y_out, 12'h3A5);
      chk("twb_fail_pop", stk_pop, 0);
      cond(1'b1);
      #1;
      chk("twb_pass_y", y_out, 12'h300);
      chk("twb_pass_pop", stk_pop, 1);

      // Enables and full flag
      instr = OP_JMAP;
      #1;
      chk("jmap_en", {pl_n, map_n, vect_n}, 3'b101);
      instr = OP_CJV;
      #1;
      chk("cjv_en", {pl_n, map_n, vect_n}, 3'b110);
      instr = OP_CONT;
      #1;
      chk("cont_en", {pl_n, map_n, vect_n}, 3'b011);
      chk("full_n_idle", full_n, 1);
      stk_full = 1'b1;
      #1;
      chk("full_n_set", full_n, 0);
      stk_full = 1'b0;

      // uPC wraps from all-ones to 0
      instr = OP_CJP; ccen_n = 1'b1; d_in = 12'hFFF; ci = 1'b1;
      tick();
      instr = OP_CONT; ci = 1'b0;
      #1;
      chk("upc_wrap", y_out, 12'h000);

      // Async reset in the middle of LOOP
      instr = OP_CJP; ccen_n = 1'b1; d_in = 12'h0AB;
      tick();
      instr = OP_LDCT; d_in = 12'h007;
      tick();
      instr = OP_LOOP; cond(1'b0); stk_dout = 12'h0AB;
      #1;
      chk("loop_fail_y", y_out, 12'h0AB);
      reset_n = 1'b0;
      #1;
      instr = OP_CONT;
      #0.1;
      chk("arst_upc", y_out, 12'h000);
      instr = OP_JRP; cond(1'b0);
      #0.1;
      chk("arst_r", y_out, 12'h000);
      instr = OP_LOOP; cond(1'b1);
      #0.1;
      chk("arst_no_pop", stk_pop, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
